// File: rtl/rb_frame_sequencer.sv
// Frame controller for the row-buffer line-buffer datapath: preload RBS-1 rows, then stream window columns.
// Define RB_SEQ_STALL_CNT_EN to build the backpressure stall counter; otherwise stall_cnt is tied to 0.
module rb_frame_sequencer #(
    parameter int RB_DEPTH = 512,
    parameter int RBS      = 4,
    parameter int IMG_ROWS = 512,
    parameter int EMEM_LAT = 1,
    parameter int READ_LAT = 2
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        start,
    input  logic                        out_ready,
    output logic                        en_e_mem_addr,
    output logic                        en_w_bram_addr,
    output logic                        en_r_bram_addr,
    output logic                        win_valid,
    output logic                        busy,
    output logic                        done,
    output logic [$clog2(IMG_ROWS)-1:0] row_cnt,
    output logic [$clog2(RB_DEPTH)-1:0] col_cnt,
    output logic [31:0]                 stall_cnt
);
    localparam int RW          = $clog2(IMG_ROWS);
    localparam int CW          = $clog2(RB_DEPTH);
    localparam int PRE_FETCHES = (RBS - 1) * RB_DEPTH;
    localparam int FW          = $clog2(PRE_FETCHES + 1);
    localparam int FLUSH_LEN   = (EMEM_LAT > READ_LAT) ? EMEM_LAT : READ_LAT;
    localparam int LW          = $clog2(FLUSH_LEN + 1);
    localparam int LAST_ROW    = IMG_ROWS - RBS;

    typedef enum logic [2:0] {S_IDLE, S_PRELOAD, S_STREAM, S_FLUSH, S_DONE} state_t;

    state_t          state_q, state_d;
    logic [FW-1:0]   fetch_q, fetch_d;
    logic [RW-1:0]   row_q, row_d;
    logic [CW-1:0]   col_q, col_d;
    logic [LW-1:0]   flush_q, flush_d;
    logic [EMEM_LAT-1:0] ew_q, ew_d;
    logic [READ_LAT-1:0] rv_q, rv_d;
    logic            last_read;

    // Handshake: in STREAM a column is consumed (one fetch + one read) in every cycle out_ready=1;
    // out_ready=0 stalls everything. PRELOAD and the other states ignore out_ready.
    assign last_read = (row_q == RW'(LAST_ROW)) && (col_q == CW'(RB_DEPTH - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            fetch_q <= '0;
            row_q   <= '0;
            col_q   <= '0;
            flush_q <= '0;
            ew_q    <= '0;
            rv_q    <= '0;
        end else begin
            state_q <= state_d;
            fetch_q <= fetch_d;
            row_q   <= row_d;
            col_q   <= col_d;
            flush_q <= flush_d;
            ew_q    <= ew_d;
            rv_q    <= rv_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:    if (start) state_d = S_PRELOAD;
            S_PRELOAD: if (fetch_q == FW'(PRE_FETCHES - 1)) state_d = S_STREAM;
            S_STREAM:  if (out_ready && last_read) state_d = S_FLUSH;
            S_FLUSH:   if (flush_q == LW'(FLUSH_LEN - 1)) state_d = S_DONE;
            S_DONE:    state_d = S_IDLE;
            default:   state_d = S_IDLE;
        endcase
    end

    always_comb begin
        en_e_mem_addr  = 1'b0;
        en_r_bram_addr = 1'b0;
        busy           = (state_q != S_IDLE);
        done           = (state_q == S_DONE);
        case (state_q)
            S_PRELOAD: en_e_mem_addr = 1'b1;
            S_STREAM: begin
                en_e_mem_addr  = out_ready;
                en_r_bram_addr = out_ready;
            end
            default: ;
        endcase
    end

    // Row/col hold on the final read so they report the last window position through DONE and IDLE.
    always_comb begin
        fetch_d = fetch_q;
        row_d   = row_q;
        col_d   = col_q;
        flush_d = '0;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    fetch_d = '0;
                    row_d   = '0;
                    col_d   = '0;
                end
            end
            S_PRELOAD: fetch_d = fetch_q + 1'b1;
            S_STREAM: begin
                if (out_ready && !last_read) begin
                    if (col_q == CW'(RB_DEPTH - 1)) begin
                        col_d = '0;
                        row_d = row_q + 1'b1;
                    end else begin
                        col_d = col_q + 1'b1;
                    end
                end
            end
            S_FLUSH: flush_d = flush_q + 1'b1;
            default: ;
        endcase
    end

    // Delay lines keep shifting in every state so FLUSH drains the in-flight beats.
    always_comb begin
        ew_d = (ew_q << 1) | EMEM_LAT'(en_e_mem_addr);
        rv_d = (rv_q << 1) | READ_LAT'(en_r_bram_addr);
    end

    assign en_w_bram_addr = ew_q[EMEM_LAT-1];
    assign win_valid      = rv_q[READ_LAT-1];
    assign row_cnt        = row_q;
    assign col_cnt        = col_q;

`ifdef RB_SEQ_STALL_CNT_EN
    logic [31:0] stall_q, stall_d;

    always_comb begin
        stall_d = stall_q;
        if (state_q == S_IDLE && start) begin
            stall_d = '0;
        end else if (state_q == S_STREAM && !out_ready && stall_q != 32'hFFFF_FFFF) begin
            stall_d = stall_q + 32'd1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) stall_q <= '0;
        else        stall_q <= stall_d;
    end

    assign stall_cnt = stall_q;
`else
    assign stall_cnt = 32'd0;
`endif

endmodule

// File: tb/tb_rb_frame_sequencer.sv
// Directed bench for rb_frame_sequencer: main instance IMG_ROWS=6, second instance IMG_ROWS=RBS=4.
// Cycle monitors tally enable pulses and delay-line alignment; each checkpoint is an immediate assertion.
module tb_rb_frame_sequencer;
    localparam int RB_DEPTH = 8;
    localparam int RBS      = 4;
    localparam int IMG_ROWS = 6;
    localparam int EMEM_LAT = 1;
    localparam int READ_LAT = 2;
`ifdef RB_SEQ_STALL_CNT_EN
    localparam int ALT_STALLS = 24;
`else
    localparam int ALT_STALLS = 0;
`endif

    // ---------------- clock / reset / DUT ----------------
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_n, start, out_ready;
    logic        en_e, en_w, en_r, win_valid, busy, done;
    logic [2:0]  row_cnt, col_cnt;
    logic [31:0] stall_cnt;

    logic        start4, rdy4;
    logic        en_e4, en_w4, en_r4, wv4, busy4, done4;
    logic [1:0]  row4;
    logic [2:0]  col4;
    logic [31:0] stall4;

    rb_frame_sequencer #(
        .RB_DEPTH(RB_DEPTH), .RBS(RBS), .IMG_ROWS(IMG_ROWS),
        .EMEM_LAT(EMEM_LAT), .READ_LAT(READ_LAT)
    ) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .out_ready(out_ready),
        .en_e_mem_addr(en_e), .en_w_bram_addr(en_w), .en_r_bram_addr(en_r),
        .win_valid(win_valid), .busy(busy), .done(done),
        .row_cnt(row_cnt), .col_cnt(col_cnt), .stall_cnt(stall_cnt)
    );

    rb_frame_sequencer #(
        .RB_DEPTH(RB_DEPTH), .RBS(RBS), .IMG_ROWS(RBS),
        .EMEM_LAT(EMEM_LAT), .READ_LAT(READ_LAT)
    ) dut4 (
        .clk(clk), .rst_n(rst_n), .start(start4), .out_ready(rdy4),
        .en_e_mem_addr(en_e4), .en_w_bram_addr(en_w4), .en_r_bram_addr(en_r4),
        .win_valid(wv4), .busy(busy4), .done(done4),
        .row_cnt(row4), .col_cnt(col4), .stall_cnt(stall4)
    );

    // ---------------- monitors ----------------
    logic mon_clr = 1'b0;
    int   cyc = 0;
    int   n_fetch, n_pre, n_write, n_read, n_wv, n_done;
    int   first_fe_cyc, last_rd_cyc, done_cyc, w_err, v_err, seq_err;
    logic prev_e, prev_r1, prev_r2;

    always @(negedge clk) begin
        cyc <= cyc + 1;
        if (!rst_n) begin
            prev_e  <= 1'b0;
            prev_r1 <= 1'b0;
            prev_r2 <= 1'b0;
        end else begin
            prev_e  <= en_e;
            prev_r1 <= en_r;
            prev_r2 <= prev_r1;
        end
        if (mon_clr) begin
            n_fetch <= 0; n_pre <= 0; n_write <= 0; n_read <= 0; n_wv <= 0; n_done <= 0;
            first_fe_cyc <= 0; last_rd_cyc <= 0; done_cyc <= 0;
            w_err <= 0; v_err <= 0; seq_err <= 0;
        end else begin
            if (en_e) begin
                n_fetch <= n_fetch + 1;
                if (n_fetch == 0) first_fe_cyc <= cyc;
            end
            if (en_e && !en_r) n_pre <= n_pre + 1;
            if (en_w) n_write <= n_write + 1;
            if (en_r) begin
                n_read      <= n_read + 1;
                last_rd_cyc <= cyc;
                // read k must present window position (k / RB_DEPTH, k % RB_DEPTH)
                if (int'(row_cnt) != n_read / RB_DEPTH || int'(col_cnt) != n_read % RB_DEPTH)
                    seq_err <= seq_err + 1;
            end
            if (win_valid) n_wv <= n_wv + 1;
            if (done) begin
                n_done   <= n_done + 1;
                done_cyc <= cyc;
            end
            if (rst_n && en_w !== prev_e) w_err <= w_err + 1;
            if (rst_n && win_valid !== prev_r2) v_err <= v_err + 1;
        end
    end

    int n4_fetch = 0, n4_pre = 0, n4_write = 0, n4_read = 0, n4_wv = 0, n4_done = 0, row4_nz = 0;
    always @(negedge clk) begin
        if (en_e4) n4_fetch <= n4_fetch + 1;
        if (en_e4 && !en_r4) n4_pre <= n4_pre + 1;
        if (en_w4) n4_write <= n4_write + 1;
        if (en_r4) n4_read <= n4_read + 1;
        if (wv4) n4_wv <= n4_wv + 1;
        if (done4) n4_done <= n4_done + 1;
        if (busy4 && row4 != 2'd0) row4_nz <= row4_nz + 1;
    end

    // ---------------- scoreboard counters / check ----------------
    int n_pass = 0, n_fail = 0, n_total = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // ---------------- driver tasks ----------------
    task automatic clear_mon();
        @(posedge clk);
        #1 mon_clr = 1'b1;
        @(negedge clk);
        #1 mon_clr = 1'b0;
    endtask

    // Runs one frame; alt toggles out_ready every cycle (STREAM opens with out_ready=0),
    // inj pulses start during PRELOAD, STREAM and the DONE cycle.
    task automatic run_frame(input string tag, input bit alt, input bit inj, input int budget);
        bit ok = 1'b0;
        int busy_err = 0;
        clear_mon();
        @(posedge clk);
        #1 start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        out_ready = alt ? 1'b0 : 1'b1;
        for (int c = 0; c < budget; c++) begin
            @(posedge clk);
            #1;
            start = 1'b0;
            if (alt) out_ready = ~out_ready;
            if (n_done > 0) begin
                ok = 1'b1;
                break;
            end
            if (busy !== 1'b1) busy_err++;
            if (inj && (c == 10 || c == 40 || done)) start = 1'b1;
        end
        start = 1'b0;
        check({tag, "_timeout"}, 32'(ok), 32'd1);
        check({tag, "_busy_held"}, 32'(busy_err), 32'd0);
    endtask

    // ---------------- directed sequence ----------------
    initial begin
        rst_n = 1'b0; start = 1'b0; out_ready = 1'b0; start4 = 1'b0; rdy4 = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_enables", {29'd0, en_e, en_w, en_r}, 32'd0);
        check("rst_flags", {29'd0, win_valid, busy, done}, 32'd0);
        check("rst_counters", {26'd0, row_cnt, col_cnt}, 32'd0);
        check("rst_stall", stall_cnt, 32'd0);
        @(posedge clk);
        #1 rst_n = 1'b1;

        // constant out_ready
        run_frame("const", 1'b0, 1'b0, 200);
        check("const_preload", 32'(n_pre), 32'd24);
        check("const_fetches", 32'(n_fetch), 32'd48);
        check("const_writes", 32'(n_write), 32'd48);
        check("const_reads", 32'(n_read), 32'd24);
        check("const_win_valid", 32'(n_wv), 32'd24);
        check("const_done_cnt", 32'(n_done), 32'd1);
        check("const_w_align", 32'(w_err), 32'd0);
        check("const_v_align", 32'(v_err), 32'd0);
        check("const_rowcol_seq", 32'(seq_err), 32'd0);
        // last read, two FLUSH cycles, then DONE
        check("const_done_lag", 32'(done_cyc - last_rd_cyc), 32'd3);
        check("const_span", 32'(last_rd_cyc - first_fe_cyc), 32'd47);
        @(negedge clk);
        check("const_idle_busy", {31'd0, busy}, 32'd0);
        check("const_final_row", {29'd0, row_cnt}, 32'd2);
        check("const_final_col", {29'd0, col_cnt}, 32'd7);
        check("const_stall", stall_cnt, 32'd0);

        // out_ready alternating
        run_frame("alt", 1'b1, 1'b0, 300);
        check("alt_preload", 32'(n_pre), 32'd24);
        check("alt_fetches", 32'(n_fetch), 32'd48);
        check("alt_reads", 32'(n_read), 32'd24);
        check("alt_writes", 32'(n_write), 32'd48);
        check("alt_win_valid", 32'(n_wv), 32'd24);
        check("alt_rowcol_seq", 32'(seq_err), 32'd0);
        check("alt_w_align", 32'(w_err), 32'd0);
        check("alt_v_align", 32'(v_err), 32'd0);
        check("alt_span", 32'(last_rd_cyc - first_fe_cyc), 32'd71);
        check("alt_done_cnt", 32'(n_done), 32'd1);
        @(negedge clk);
        check("alt_stall", stall_cnt, 32'(ALT_STALLS));
        check("alt_final_row", {29'd0, row_cnt}, 32'd2);

        // start pulses during PRELOAD, STREAM and DONE are ignored
        run_frame("inj", 1'b0, 1'b1, 200);
        check("inj_fetches", 32'(n_fetch), 32'd48);
        check("inj_reads", 32'(n_read), 32'd24);
        check("inj_done_cnt", 32'(n_done), 32'd1);
        repeat (3) @(negedge clk);
        check("inj_no_restart_busy", {31'd0, busy}, 32'd0);
        check("inj_no_restart_fetch", 32'(n_fetch), 32'd48);

        // reset during STREAM
        begin
            bit hit = 1'b0;
            clear_mon();
            @(posedge clk);
            #1 start = 1'b1;
            @(posedge clk);
            #1 start = 1'b0;
            out_ready = 1'b1;
            for (int c = 0; c < 100; c++) begin
                @(posedge clk);
                #1;
                if (n_read >= 5) begin
                    hit = 1'b1;
                    break;
                end
            end
            check("rstmid_reach_read5", 32'(hit), 32'd1);
            rst_n = 1'b0;
            #1;
            check("rstmid_enables", {29'd0, en_e, en_w, en_r}, 32'd0);
            check("rstmid_flags", {29'd0, win_valid, busy, done}, 32'd0);
            check("rstmid_counters", {26'd0, row_cnt, col_cnt}, 32'd0);
            check("rstmid_stall", stall_cnt, 32'd0);
            repeat (2) @(posedge clk);
            #1 rst_n = 1'b1;
            clear_mon();
            repeat (10) @(negedge clk);
            check("rstmid_no_writes", 32'(n_write), 32'd0);
            check("rstmid_no_win_valid", 32'(n_wv), 32'd0);
            check("rstmid_idle", {31'd0, busy}, 32'd0);
        end
        run_frame("post_rst", 1'b0, 1'b0, 200);
        check("post_rst_fetches", 32'(n_fetch), 32'd48);
        check("post_rst_win_valid", 32'(n_wv), 32'd24);
        check("post_rst_done_cnt", 32'(n_done), 32'd1);
        check("post_rst_w_align", 32'(w_err), 32'd0);
        check("post_rst_v_align", 32'(v_err), 32'd0);

        // IMG_ROWS == RBS instance
        begin
            bit ok4 = 1'b0;
            @(posedge clk);
            #1 start4 = 1'b1;
            rdy4 = 1'b1;
            @(posedge clk);
            #1 start4 = 1'b0;
            for (int c = 0; c < 200; c++) begin
                @(posedge clk);
                #1;
                if (n4_done > 0) begin
                    ok4 = 1'b1;
                    break;
                end
            end
            check("r4_timeout", 32'(ok4), 32'd1);
            repeat (3) @(negedge clk);
            check("r4_preload", 32'(n4_pre), 32'd24);
            check("r4_fetches", 32'(n4_fetch), 32'd32);
            check("r4_writes", 32'(n4_write), 32'd32);
            check("r4_reads", 32'(n4_read), 32'd8);
            check("r4_win_valid", 32'(n4_wv), 32'd8);
            check("r4_done_cnt", 32'(n4_done), 32'd1);
            check("r4_row_nonzero", 32'(row4_nz), 32'd0);
            check("r4_final_col", {29'd0, col4}, 32'd7);
            check("r4_idle_busy", {31'd0, busy4}, 32'd0);
            check("r4_stall", stall4, 32'd0);
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
